// File: rtl/cpu_step_ctrl.sv
// Execution sequencer for the 4-bit LED-matrix CPU: turns button input, a prescaled run rate
// and a PC breakpoint into a one-clock step enable for the core.
module cpu_step_ctrl #(
    parameter int unsigned PRESCALE_W   = 24,
    parameter int unsigned DEBOUNCE_W   = 16,
    parameter bit          RUN_AT_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_n,
    input  logic       btn_step_n,
    input  logic [3:0] pc,
    input  logic [3:0] bp_addr,
    input  logic       bp_en,
    output logic       step_en,
    output logic       running,
    output logic       bp_hit,
    output logic [7:0] step_count
);

    typedef enum logic [1:0] {StHalt, StRun, StStep, StBrk} state_e;

    localparam state_e ResetState = RUN_AT_RESET ? StRun : StHalt;

    // Button index 0 is run/halt, index 1 is single-step.
    logic [1:0]            btn_raw;
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            stable_q, stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q [2];
    logic [DEBOUNCE_W-1:0] cnt_d [2];
    logic [1:0]            press;
    logic                  run_press, step_press;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  skip_q, skip_d;
    logic                  step_en_q, step_en_d;
    logic                  running_q, running_d;
    logic                  bp_hit_q, bp_hit_d;
    logic [7:0]            step_count_q, step_count_d;
    logic                  tick, bp_match;

    assign btn_raw = {btn_step_n, btn_run_n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            stable_q <= 2'b11;
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any disagreement restarts only when synced matches stable again; a full count commits.
    always_comb begin
        stable_d = stable_q;
        press    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (&cnt_q[i]) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    assign run_press  = press[0];
    assign step_press = press[1];

    assign tick     = &prescale_q;
    assign bp_match = bp_en && (pc == bp_addr) && !skip_q;

    always_comb begin
        state_d    = state_q;
        prescale_d = '0;
        skip_d     = skip_q;
        step_en_d  = 1'b0;
        case (state_q)
            StRun: begin
                // A run press takes priority and drops a tick landing in the same cycle.
                if (run_press) begin
                    state_d = StHalt;
                end else begin
                    prescale_d = prescale_q + PRESCALE_W'(1);
                    if (tick) begin
                        if (bp_match) begin
                            state_d = StBrk;
                        end else begin
                            step_en_d = 1'b1;
                            skip_d    = 1'b0;
                        end
                    end
                end
            end
            StHalt: begin
                if (run_press) begin
                    state_d = StRun;
                    skip_d  = 1'b0;
                end else if (step_press) begin
                    state_d   = StStep;
                    step_en_d = 1'b1;
                end
            end
            StStep: begin
                state_d = StHalt;
            end
            StBrk: begin
                // Leaving a breakpoint by run must not re-trap on the same pc.
                if (run_press) begin
                    state_d = StRun;
                    skip_d  = 1'b1;
                end else if (step_press) begin
                    state_d   = StStep;
                    step_en_d = 1'b1;
                end
            end
            default: begin
                state_d = StHalt;
            end
        endcase
        running_d    = (state_d == StRun);
        bp_hit_d     = (state_d == StBrk);
        step_count_d = step_en_d ? step_count_q + 8'd1 : step_count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ResetState;
            prescale_q   <= '0;
            skip_q       <= 1'b0;
            step_en_q    <= 1'b0;
            running_q    <= RUN_AT_RESET;
            bp_hit_q     <= 1'b0;
            step_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            skip_q       <= skip_d;
            step_en_q    <= step_en_d;
            running_q    <= running_d;
            bp_hit_q     <= bp_hit_d;
            step_count_q <= step_count_d;
        end
    end

    assign step_en    = step_en_q;
    assign running    = running_q;
    assign bp_hit     = bp_hit_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with a short prescaler and debouncer; a second instance
// built with RUN_AT_RESET=0 covers the halt-at-reset variant.
module tb_cpu_step_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run_n, btn_step_n;
    logic       h_btn_run_n, h_btn_step_n;
    logic [3:0] pc, bp_addr;
    logic       bp_en;
    logic       step_en, running, bp_hit;
    logic [7:0] step_count;
    logic       h_step_en, h_running, h_bp_hit;
    logic [7:0] h_step_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int h_pulses = 0;
    int p0;
    logic prev_step = 1'b0;
    logic consec = 1'b0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.PRESCALE_W(4), .DEBOUNCE_W(2), .RUN_AT_RESET(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_run_n  (btn_run_n),
        .btn_step_n (btn_step_n),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .step_en    (step_en),
        .running    (running),
        .bp_hit     (bp_hit),
        .step_count (step_count)
    );

    cpu_step_ctrl #(.PRESCALE_W(4), .DEBOUNCE_W(2), .RUN_AT_RESET(1'b0)) dut_h (
        .clk        (clk),
        .rst        (rst),
        .btn_run_n  (h_btn_run_n),
        .btn_step_n (h_btn_step_n),
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .step_en    (h_step_en),
        .running    (h_running),
        .bp_hit     (h_bp_hit),
        .step_count (h_step_count)
    );

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (step_en) pulses <= pulses + 1;
        if (step_en && prev_step) consec <= 1'b1;
        prev_step <= step_en;
        if (h_step_en) h_pulses <= h_pulses + 1;
    end

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_run_n = 1'b1;
        btn_step_n = 1'b1;
        h_btn_run_n = 1'b1;
        h_btn_step_n = 1'b1;
        pc = 4'd0;
        bp_addr = 4'd0;
        bp_en = 1'b0;
        #1 rst = 1'b0;
        step_clk(3);
        check("rst_step_en", step_en, 0);
        check("rst_running", running, 1);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_count", step_count, 0);
        check("rst_h_running", h_running, 0);
        rst = 1'b1;

        // Free run: ticks at clocks 16, 32, 48.
        step_clk(15);
        check("run_pre_tick", step_en, 0);
        step_clk(1);
        check("run_tick1", step_en, 1);
        check("run_count1", step_count, 1);
        step_clk(1);
        check("run_tick1_end", step_en, 0);
        step_clk(31);
        check("run_tick3", step_en, 1);
        check("run_count3", step_count, 3);
        check("run_running", running, 1);

        // Run press halts 6 clocks later.
        btn_run_n = 1'b0;
        step_clk(5);
        check("halt_not_yet", running, 1);
        step_clk(1);
        check("halt_running", running, 0);
        check("halt_step_en", step_en, 0);
        step_clk(4);
        btn_run_n = 1'b1;
        step_clk(30);
        check("halt_quiet_count", step_count, 3);
        check("halt_quiet_pulses", pulses, 3);

        // Single step from HALT.
        btn_step_n = 1'b0;
        step_clk(5);
        check("step_not_yet", step_en, 0);
        step_clk(1);
        check("step_pulse", step_en, 1);
        check("step_count", step_count, 4);
        check("step_running", running, 0);
        step_clk(1);
        check("step_pulse_end", step_en, 0);
        step_clk(3);
        btn_step_n = 1'b1;
        step_clk(20);
        check("step_total_pulses", pulses, 4);
        check("step_back_halt", running, 0);

        // Simultaneous run and step press: run wins.
        btn_run_n = 1'b0;
        btn_step_n = 1'b0;
        step_clk(6);
        check("both_running", running, 1);
        check("both_no_step", step_en, 0);
        check("both_count", step_count, 4);
        step_clk(4);
        btn_run_n = 1'b1;
        btn_step_n = 1'b1;
        step_clk(12);
        check("both_first_tick", step_en, 1);
        check("both_tick_count", step_count, 5);

        // Breakpoint at pc 5.
        bp_en = 1'b1;
        bp_addr = 4'd5;
        pc = 4'd5;
        step_clk(16);
        check("bp_no_step", step_en, 0);
        check("bp_hit", bp_hit, 1);
        check("bp_running", running, 0);
        check("bp_count", step_count, 5);
        btn_run_n = 1'b0;
        step_clk(6);
        check("bp_resume_hit", bp_hit, 0);
        check("bp_resume_running", running, 1);
        step_clk(4);
        btn_run_n = 1'b1;
        step_clk(12);
        check("bp_skip_step", step_en, 1);
        check("bp_skip_count", step_count, 6);
        step_clk(16);
        check("bp_retrap_hit", bp_hit, 1);
        check("bp_retrap_step", step_en, 0);
        btn_step_n = 1'b0;
        step_clk(6);
        check("bp_step_pulse", step_en, 1);
        check("bp_step_hit_drop", bp_hit, 0);
        check("bp_step_count", step_count, 7);
        step_clk(1);
        check("bp_step_end", step_en, 0);
        check("bp_step_halt", running, 0);
        step_clk(3);
        btn_step_n = 1'b1;
        step_clk(20);

        // Bouncing step button yields exactly one step.
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            btn_step_n = ~btn_step_n;
            step_clk(1);
        end
        btn_step_n = 1'b0;
        step_clk(10);
        check("bounce_pulses", pulses - p0, 1);
        check("bounce_count", step_count, 8);
        btn_step_n = 1'b1;
        step_clk(20);
        check("bounce_halt", running, 0);

        // Reset during the STEP cycle.
        btn_step_n = 1'b0;
        step_clk(6);
        check("rst_mid_pre", step_en, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_step_en", step_en, 0);
        check("rst_mid_count", step_count, 0);
        check("rst_mid_running", running, 1);
        check("rst_mid_bp_hit", bp_hit, 0);
        btn_step_n = 1'b1;
        bp_en = 1'b0;
        step_clk(2);
        rst = 1'b1;
        p0 = h_pulses;
        step_clk(100);
        check("h_no_steps", h_pulses - p0, 0);
        check("h_running", h_running, 0);
        check("h_count", h_step_count, 0);
        check("after_rst_count", step_count, 6);
        check("no_consecutive", consec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
